// File: rtl/case_decode_pipe.sv
// Selector-to-one-hot decoder behind a two-entry (main + skid) valid/ready pipeline stage.
// Optional saturating miss counter is built when CASE_DECODE_MISS_CNT_EN is defined.
module case_decode_pipe #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned NUM_OUT = 6,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_miss
`ifdef CASE_DECODE_MISS_CNT_EN
    ,
    output logic [CNT_W-1:0]   miss_count
`endif
);

    if (NUM_OUT < 1 || NUM_OUT > (1 << SEL_W) || CNT_W < 1) begin : g_param_err
        $error("case_decode_pipe: illegal parameter combination");
    end

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;

    logic [NUM_OUT-1:0] in_onehot;
    logic               in_miss;
    logic               in_xfer;
    logic               out_xfer;

    logic [NUM_OUT-1:0] main_onehot_q, main_onehot_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic               main_miss_q, main_miss_d;
    logic [NUM_OUT-1:0] skid_onehot_q, skid_onehot_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic               skid_miss_q, skid_miss_d;

    // Decode at the input so stored entries already hold the final one-hot form.
    always_comb begin
        in_onehot = '0;
        in_miss   = 1'b1;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                in_onehot[k] = 1'b1;
                in_miss      = 1'b0;
            end
        end
    end

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        main_onehot_d = main_onehot_q;
        main_data_d   = main_data_q;
        main_miss_d   = main_miss_q;
        skid_onehot_d = skid_onehot_q;
        skid_data_d   = skid_data_q;
        skid_miss_d   = skid_miss_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d       = StOne;
                    main_onehot_d = in_onehot;
                    main_data_d   = in_data;
                    main_miss_d   = in_miss;
                end
            end
            StOne: begin
                if (in_xfer && !out_xfer) begin
                    state_d       = StTwo;
                    skid_onehot_d = in_onehot;
                    skid_data_d   = in_data;
                    skid_miss_d   = in_miss;
                end else if (in_xfer && out_xfer) begin
                    main_onehot_d = in_onehot;
                    main_data_d   = in_data;
                    main_miss_d   = in_miss;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only the skid-to-main shift can happen.
                if (out_xfer) begin
                    state_d       = StOne;
                    main_onehot_d = skid_onehot_q;
                    main_data_d   = skid_data_q;
                    main_miss_d   = skid_miss_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StEmpty;
            main_onehot_q <= '0;
            main_data_q   <= '0;
            main_miss_q   <= 1'b0;
            skid_onehot_q <= '0;
            skid_data_q   <= '0;
            skid_miss_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            main_onehot_q <= main_onehot_d;
            main_data_q   <= main_data_d;
            main_miss_q   <= main_miss_d;
            skid_onehot_q <= skid_onehot_d;
            skid_data_q   <= skid_data_d;
            skid_miss_q   <= skid_miss_d;
        end
    end

    // Gate with out_valid so an empty stage always presents zeros.
    assign out_onehot = out_valid ? main_onehot_q : '0;
    assign out_data   = out_valid ? main_data_q : '0;
    assign out_miss   = out_valid && main_miss_q;

`ifdef CASE_DECODE_MISS_CNT_EN
    logic [CNT_W-1:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_q <= '0;
        end else if (in_xfer && in_miss && (miss_cnt_q != {CNT_W{1'b1}})) begin
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    assign miss_count = miss_cnt_q;
`else
    // No counter: misses are only reported per item through out_miss.
`endif

endmodule

// File: doc/case_decode_pipe.md
CASE_DECODE_PIPE -- requirements
Module: case_decode_pipe

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, selector width in bits.
REQ-002 The block SHALL have parameter NUM_OUT, default 6, number of decoded outputs, legal range 1..2**SEL_W.
REQ-003 The block SHALL have parameter DATA_W, default 8, width of the payload carried alongside each selector.
REQ-004 The block SHALL have parameter CNT_W, default 16, width of the miss counter.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  upstream item valid
- in_ready  output  1  block can accept an item
- in_sel  input  SEL_W  selector to decode
- in_data  input  DATA_W  payload
- out_valid  output  1  decoded item valid
- out_ready  input  1  downstream accepts item
- out_onehot  output  NUM_OUT  decoded one-hot, zero on miss
- out_data  output  DATA_W  payload of presented item
- out_miss  output  1  presented item had in_sel >= NUM_OUT
- miss_count  output  CNT_W  saturating miss count (present only with macro, see REQ-019)

Function
REQ-006 An input transfer SHALL occur on a rising edge where in_valid && in_ready, and an output transfer SHALL occur where out_valid && out_ready.
REQ-007 Decoding SHALL set out_onehot[k]=1 only for k==in_sel when in_sel<NUM_OUT, and otherwise all-zero with out_miss=1 (implicit default; no X ever driven).
REQ-008 Storage SHALL be two entries (main + skid); occupancy FSM states EMPTY, ONE, TWO.
REQ-009 Transitions SHALL be: EMPTY->ONE on input transfer; ONE->TWO on input without output; ONE->EMPTY on output without input; ONE->ONE on simultaneous input and output; TWO->ONE on output.
REQ-010 in_ready SHALL equal (state != TWO), derived from registered state only (no combinational path from out_ready).
REQ-011 out_valid SHALL equal (state != EMPTY).
REQ-012 Latency SHALL be exactly one cycle: an item accepted at edge N SHALL be visible on outputs after edge N when state was EMPTY, or in the ONE state with simultaneous output.
REQ-013 Ordering SHALL be strict FIFO; on TWO->ONE the skid entry SHALL move to the main entry in the same edge.
REQ-014 Outputs out_onehot, out_data and out_miss SHALL remain stable while out_valid && !out_ready.
REQ-015 in_valid SHALL be ignored while in_ready=0 (no transfer, no state change).

Reset
REQ-016 On rst assertion the state SHALL go to EMPTY asynchronously: out_valid=0, in_ready=1, out_onehot=0, out_data=0, out_miss=0, miss_count=0.
REQ-017 Reset mid-operation SHALL discard all stored items; no output transfer SHALL complete in the cycle of reset release.
REQ-018 The first transfer after release SHALL be possible at the first rising edge where rst=0.

Configuration
REQ-019 Macro CASE_DECODE_MISS_CNT_EN defined: miss_count SHALL increment by 1 on each input transfer with in_sel>=NUM_OUT, saturating at 2**CNT_W-1.
REQ-020 Macro undefined: miss_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-021 Reset, then in_sel=2, in_data=8'hA5, out_ready=1 for one transfer -> next cycle out_valid=1, out_onehot=6'b000100, out_data=8'hA5, out_miss=0.
REQ-022 in_sel=7 (NUM_OUT=6) -> out_onehot=6'b000000, out_miss=1; with macro, miss_count goes 0->1.
REQ-023 out_ready=0, push sel 0, 1, 3 back-to-back -> in_ready=0 after second transfer; third item held off; out_onehot stays 6'b000001 for all stalled cycles.
REQ-024 Then release out_ready=1 -> outputs 6'b000001, 6'b000010, 6'b001000 in order, no loss or duplication.
REQ-025 With macro and CNT_W=2, five miss transfers -> miss_count=3 (saturated).
REQ-026 Assert rst while state=TWO -> immediately out_valid=0, in_ready=1; after release, stale items never appear.
